axis_cordic_sched: RTL and testbench
====================================

// Module: axis_cordic_sched
// PURPOSE
//  Shares one axi_cordic engine between N_REQ AXI-Stream requesters. Round-robin picks a channel and
//  forwards its {y,x} sample to the engine. It then captures the {angle,magnitude} result and routes
//  it back to the requesting channel only. One transaction is in flight at a time.
//  A watchdog flags and recovers from a non-responding engine.
// PARAMETERS
//  N_REQ        4    number of requester channels (2..8)
//  DATA_WIDTH   32   tdata width; {y[31:16],x[15:0]} in, {angle[31:16],mag[15:0]} out
//  TIMEOUT      64   max cycles in WAIT before abort (must exceed engine latency of 19)
// PORTS
//  s00_axis_aclk     in   1                 single clock for all interfaces
//  s00_axis_aresetn  in   1                 synchronous, active-low reset
//  s00_axis_tvalid   in   N_REQ             per-requester sample valid
//  s00_axis_tdata    in   N_REQ*DATA_WIDTH  packed samples; chan i at [i*DW +: DW]
//  s00_axis_tlast    in   N_REQ             per-requester tlast
//  s00_axis_tready   out  N_REQ             one-hot accept for each requester
//  m00_axis_tvalid   out  N_REQ             one-hot result valid for the owner channel
//  m00_axis_tdata    out  DATA_WIDTH        result data, shared by all channels
//  m00_axis_tlast    out  1                 tlast of the owner's accepted sample
//  m00_axis_tready   in   N_REQ             per-requester result ready
//  m01_axis_tvalid/tdata/tlast  out 1/DW/1   sample to the engine's s00_axis
//  m01_axis_tready   in   1                 from the engine's s00_axis_tready
//  s01_axis_tvalid/tdata  in 1/DW           result from the engine's m00_axis
//  s01_axis_tready   out  1                 to the engine's m00_axis_tready
//  busy              out  1                 state != IDLE
//  owner             out  $clog2(N_REQ)     index of the channel in flight
//  err_timeout       out  1                 sticky; cleared only by reset
//  err_chan          out  $clog2(N_REQ)     owner at the most recent timeout
// BEHAVIOUR
//  Reset values: all tvalid/tready = 0, state = IDLE, rr_ptr = 0, owner = 0, err_* = 0, data regs = 0.
//  FSM:
//   IDLE -> ISSUE   on any s00 tvalid; the accept cycle is c0.
//   ISSUE -> WAIT   on m01 tvalid & tready.
//   WAIT -> RETURN  on s01 tvalid; s01_axis_tready=1 throughout WAIT.
//   WAIT -> IDLE    when wd_cnt==TIMEOUT-1: set err_timeout, latch err_chan, drop the transaction.
//   RETURN -> IDLE  on m00_axis_tvalid[owner] & m00_axis_tready[owner].
//  IDLE:
//   - Grant g = first valid channel scanning rr_ptr, rr_ptr+1, ..., wrapping at N_REQ.
//   - s00_axis_tready = onehot(g), asserted combinationally in IDLE only.
//   - Capture tdata/tlast in hold regs; owner <= g; rr_ptr <= (g+1) mod N_REQ.
//  ISSUE:
//   - m01_axis_tvalid=1 from c1; tdata/tlast stable until m01_axis_tready.
//   - No timeout in ISSUE; the engine always becomes ready after its reset.
//  WAIT:
//   - wd_cnt clears on WAIT entry and increments each WAIT cycle.
//   - Capture s01_axis_tdata. The engine's own tlast is ignored; the held requester tlast is used.
//  RETURN:
//   - m00_axis_tvalid[owner]=1 with data/tlast stable until the handshake; all other bits are 0.
//   - The next grant can occur on the cycle after RETURN->IDLE.
//  IDLE/ISSUE/RETURN: s01_axis_tready=1 in IDLE (late post-timeout results are drained and discarded),
//   0 in ISSUE and RETURN.
//  Latency with an ideal sink: accept c0, engine accept c1, result c19, m00 valid c20.
//   Throughput is one sample per 21 cycles.
//  Data is passed through unmodified; no arithmetic on tdata.
//  A requester deasserting tvalid without a handshake is legal; it only affects arbitration in IDLE.
//  Reset mid-operation returns to IDLE the next cycle with no output pulse. The engine shares the
//   same reset, so no stale result can arrive after it.
//  Simultaneous requests from all channels: strict rotation, so each channel is served once per N_REQ grants.
// STRUCTURE
//  cordic_pkg:
//   - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} sched_state_t
//   - localparam CORDIC_LATENCY = 19
//   - typedef {y,x} / {angle,mag} packed structs
//  Sub-module rr_arbiter #(N): inputs req, ptr; outputs grant_onehot, grant_idx, any. Purely combinational.
//  Top: FSM, hold regs, watchdog counter.
// TESTING
//  1. Reset, ch1 sends 0x0000_4000 (x=16384, y=0) -> s00 tready[1] only; m00 tvalid[1] after 20 cycles;
//     angle=0x0000; mag is approximately 0x4000.
//  2. ch0..ch3 all valid continuously -> grants in order 0,1,2,3,0; each m00 tvalid is one-hot to its owner.
//  3. ch2 holds m00_axis_tready[2]=0 for 10 cycles -> data/tlast stable; no new s00 tready during the stall.
//  4. Engine model never returns a result (ch3) -> err_timeout=1, err_chan=3 at TIMEOUT cycles into WAIT.
//     A late result is drained and discarded. The next request completes normally.
//  5. Assert reset while in WAIT -> busy=0 and all valids=0 the next cycle; rr_ptr=0 afterwards.
//  6. ch0 sends tlast=1 while the engine output has tlast=0 -> m00_axis_tlast=1 on the returned beat.

Source files
------------

// File: rtl/axis_cordic_sched_pkg.sv
// Shared types and constants for the CORDIC request scheduler.
// Sample/result word layouts match the engine's tdata packing.
package axis_cordic_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RETURN
  } sched_state_t;

  localparam int CORDIC_LATENCY = 19;

  typedef struct packed {
    logic signed [15:0] y;
    logic signed [15:0] x;
  } cordic_sample_t;

  typedef struct packed {
    logic signed [15:0] angle;
    logic        [15:0] mag;
  } cordic_result_t;

  // A watchdog shorter than the engine latency would abort every transaction.
  function automatic int wd_limit(input int timeout);
    return (timeout > CORDIC_LATENCY) ? timeout : CORDIC_LATENCY + 1;
  endfunction

endpackage

// File: rtl/axis_cordic_sched_if.sv
// Handshake bundle between requesters, the scheduler and the shared CORDIC engine.
// modport master is the scheduler itself; modport slave is everything around it.
interface axis_cordic_sched_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32
);
  logic [N_REQ-1:0]            s00_axis_tvalid;
  logic [N_REQ*DATA_WIDTH-1:0] s00_axis_tdata;
  logic [N_REQ-1:0]            s00_axis_tlast;
  logic [N_REQ-1:0]            s00_axis_tready;

  logic [N_REQ-1:0]            m00_axis_tvalid;
  logic [DATA_WIDTH-1:0]       m00_axis_tdata;
  logic                        m00_axis_tlast;
  logic [N_REQ-1:0]            m00_axis_tready;

  logic                        m01_axis_tvalid;
  logic [DATA_WIDTH-1:0]       m01_axis_tdata;
  logic                        m01_axis_tlast;
  logic                        m01_axis_tready;

  logic                        s01_axis_tvalid;
  logic [DATA_WIDTH-1:0]       s01_axis_tdata;
  logic                        s01_axis_tready;

  modport master (
    input  s00_axis_tvalid, s00_axis_tdata, s00_axis_tlast,
    output s00_axis_tready,
    output m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast,
    input  m00_axis_tready,
    output m01_axis_tvalid, m01_axis_tdata, m01_axis_tlast,
    input  m01_axis_tready,
    input  s01_axis_tvalid, s01_axis_tdata,
    output s01_axis_tready
  );

  modport slave (
    output s00_axis_tvalid, s00_axis_tdata, s00_axis_tlast,
    input  s00_axis_tready,
    input  m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast,
    output m00_axis_tready,
    input  m01_axis_tvalid, m01_axis_tdata, m01_axis_tlast,
    output m01_axis_tready,
    output s01_axis_tvalid, s01_axis_tdata,
    input  s01_axis_tready
  );

endinterface

// File: rtl/axis_cordic_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant_onehot,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;

  // Scan from the farthest offset back toward ptr so the nearest request wins last.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    idx          = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant_idx = idx;
        any       = 1'b1;
      end
    end
    grant_onehot[grant_idx] = any;
  end

endmodule

// File: rtl/axis_cordic_sched.sv
// Shares one CORDIC engine among N_REQ AXI-Stream requesters, one transaction at a time,
// with a watchdog that abandons a transaction if the engine never answers.
module axis_cordic_sched
  import axis_cordic_sched_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                     s00_axis_aclk,
  input  logic                     s00_axis_aresetn,
  axis_cordic_sched_if.master      bus,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     err_timeout,
  output logic [$clog2(N_REQ)-1:0] err_chan
);

  localparam int IW      = $clog2(N_REQ);
  localparam int WD_LAST = wd_limit(TIMEOUT) - 1;
  localparam int WD_W    = $clog2(WD_LAST + 1);

  sched_state_t          state, state_nxt;
  logic [IW-1:0]         rr_ptr;
  logic [DATA_WIDTH-1:0] hold_data, res_data, grant_data;
  logic                  hold_last, grant_last, any_req;
  logic [N_REQ-1:0]      grant_onehot;
  logic [IW-1:0]         grant_idx;
  logic [WD_W-1:0]       wd_cnt;
  logic                  wd_expired;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req          (bus.s00_axis_tvalid),
    .ptr          (rr_ptr),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (any_req)
  );

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_onehot[i]) grant_data = bus.s00_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign grant_last = |(bus.s00_axis_tlast & grant_onehot);
  assign wd_expired = (wd_cnt == WD_W'(WD_LAST));

  assign busy               = (state != IDLE);
  assign bus.m01_axis_tdata = hold_data;
  assign bus.m01_axis_tlast = hold_last;
  assign bus.m00_axis_tdata = res_data;
  // The engine's own tlast is not used; the requester's tlast travels with the transaction.
  assign bus.m00_axis_tlast = hold_last;

  always_comb begin
    state_nxt           = state;
    bus.s00_axis_tready = '0;
    bus.m00_axis_tvalid = '0;
    bus.m01_axis_tvalid = 1'b0;
    bus.s01_axis_tready = 1'b0;
    case (state)
      IDLE: begin
        // Keep draining so a result arriving after a timeout never backs up the engine.
        bus.s01_axis_tready = 1'b1;
        bus.s00_axis_tready = grant_onehot;
        if (any_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        bus.m01_axis_tvalid = 1'b1;
        if (bus.m01_axis_tready) state_nxt = WAIT;
      end
      WAIT: begin
        bus.s01_axis_tready = 1'b1;
        if (bus.s01_axis_tvalid) state_nxt = RETURN;
        else if (wd_expired)     state_nxt = IDLE;
      end
      RETURN: begin
        bus.m00_axis_tvalid[owner] = 1'b1;
        if (bus.m00_axis_tready[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      hold_data   <= '0;
      hold_last   <= 1'b0;
      res_data    <= '0;
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
      err_chan    <= '0;
    end else begin
      state  <= state_nxt;
      wd_cnt <= (state == WAIT) ? wd_cnt + 1'b1 : '0;
      if (state == IDLE && any_req) begin
        hold_data <= grant_data;
        hold_last <= grant_last;
        owner     <= grant_idx;
        rr_ptr    <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (state == WAIT) begin
        if (bus.s01_axis_tvalid) begin
          res_data <= bus.s01_axis_tdata;
        end else if (wd_expired) begin
          err_timeout <= 1'b1;
          err_chan    <= owner;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_cordic_sched.sv
// Directed bench for axis_cordic_sched with a behavioural engine whose result is {y, x+1}.
module tb_axis_cordic_sched;
  import axis_cordic_sched_pkg::*;

  logic       clk;
  logic       rstn;
  logic       busy;
  logic [1:0] owner;
  logic       err_timeout;
  logic [1:0] err_chan;

  int checks = 0;
  int errors = 0;

  int             eng_delay = 17;
  logic           eng_pending;
  int             eng_cnt;
  cordic_result_t eng_word;

  logic [3:0] seen;
  logic [3:0] oh;
  logic [31:0] t2_data [4] = '{32'h1000_0010, 32'h2000_0020, 32'h3000_0030, 32'h4000_0040};
  logic [31:0] t2_res  [4] = '{32'h1000_0011, 32'h2000_0021, 32'h3000_0031, 32'h4000_0041};

  axis_cordic_sched_if #(.N_REQ(4), .DATA_WIDTH(32)) bus ();

  axis_cordic_sched #(.N_REQ(4), .DATA_WIDTH(32), .TIMEOUT(64)) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rstn),
    .bus              (bus),
    .busy             (busy),
    .owner            (owner),
    .err_timeout      (err_timeout),
    .err_chan         (err_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cordic_result_t engModel(input logic [31:0] d);
    cordic_sample_t s;
    cordic_result_t r;
    s       = d;
    r.angle = s.y;
    r.mag   = s.x + 16'd1;
    return r;
  endfunction

  // Engine answers eng_delay cycles after its accept counter starts; shares the scheduler reset.
  always @(posedge clk) begin
    if (!rstn) begin
      eng_pending         <= 1'b0;
      eng_cnt             <= 0;
      bus.s01_axis_tvalid <= 1'b0;
      bus.s01_axis_tdata  <= '0;
    end else begin
      if (bus.s01_axis_tvalid && bus.s01_axis_tready) bus.s01_axis_tvalid <= 1'b0;
      if (bus.m01_axis_tvalid && bus.m01_axis_tready) begin
        eng_pending <= 1'b1;
        eng_cnt     <= 1;
        eng_word    <= engModel(bus.m01_axis_tdata);
      end else if (eng_pending) begin
        if (eng_cnt == eng_delay) begin
          bus.s01_axis_tvalid <= 1'b1;
          bus.s01_axis_tdata  <= eng_word;
          eng_pending         <= 1'b0;
        end else begin
          eng_cnt <= eng_cnt + 1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int chan, input logic valid, input logic [31:0] data, input logic last);
    bus.s00_axis_tvalid[chan]          = valid;
    bus.s00_axis_tdata[chan*32 +: 32]  = data;
    bus.s00_axis_tlast[chan]           = last;
  endtask

  task automatic waitGrant(output logic [3:0] tr);
    int n = 0;
    #1;
    while (bus.s00_axis_tready == 4'b0 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    tr = bus.s00_axis_tready;
  endtask

  task automatic waitReturn(output logic [3:0] tv);
    int n = 0;
    @(negedge clk); #1;
    while (bus.m00_axis_tvalid == 4'b0 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    tv = bus.m00_axis_tvalid;
  endtask

  task automatic runSingle(input string tag, input int chan, input logic [31:0] data,
                           input logic last, input logic [31:0] exp_res);
    logic [3:0] hot;
    hot = 4'b0001 << chan;
    @(negedge clk);
    applyStimulus(chan, 1'b1, data, last);
    #1;
    checkOutput({tag, " grant"}, 64'(bus.s00_axis_tready), 64'(hot));
    @(negedge clk);
    applyStimulus(chan, 1'b0, data, last);
    #1;
    checkOutput({tag, " issue"}, 64'({bus.m01_axis_tvalid, bus.m01_axis_tlast, bus.m01_axis_tdata}),
                64'({1'b1, last, data}));
    repeat (18) @(negedge clk);
    #1;
    checkOutput({tag, " c19_quiet"}, 64'(bus.m00_axis_tvalid), 64'(4'b0));
    @(negedge clk); #1;
    checkOutput({tag, " result"}, 64'({bus.m00_axis_tvalid, bus.m00_axis_tlast, bus.m00_axis_tdata}),
                64'({hot, last, exp_res}));
    checkOutput({tag, " owner"}, 64'(owner), 64'(chan));
    @(negedge clk); #1;
    checkOutput({tag, " done"}, 64'({busy, bus.m00_axis_tvalid}), 64'(5'b0));
  endtask

  initial begin
    rstn                = 1'b0;
    bus.s00_axis_tvalid = '0;
    bus.s00_axis_tdata  = '0;
    bus.s00_axis_tlast  = '0;
    bus.m00_axis_tready = 4'hF;
    bus.m01_axis_tready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset outputs", 64'({busy, bus.m00_axis_tvalid, bus.m01_axis_tvalid, bus.s00_axis_tready}),
                64'(10'b0));
    checkOutput("reset err", 64'({err_timeout, err_chan, owner}), 64'(5'b0));
    rstn = 1'b1;

    $display("[TB] single request ch1");
    runSingle("t1", 1, 32'h0000_4000, 1'b0, 32'h0000_4001);

    $display("[TB] tlast passthrough ch0");
    runSingle("t6", 0, 32'h1234_0100, 1'b1, 32'h1234_0101);

    $display("[TB] output stall on ch2");
    bus.m00_axis_tready = 4'b1011;
    @(negedge clk);
    applyStimulus(2, 1'b1, 32'hABCD_00FF, 1'b1);
    #1;
    checkOutput("t3 grant", 64'(bus.s00_axis_tready), 64'(4'b0100));
    @(negedge clk);
    applyStimulus(2, 1'b0, 32'hABCD_00FF, 1'b1);
    applyStimulus(0, 1'b1, 32'h0005_0007, 1'b0);
    waitReturn(seen);
    checkOutput("t3 result", 64'({seen, bus.m00_axis_tlast, bus.m00_axis_tdata}),
                64'({4'b0100, 1'b1, 32'hABCD_0100}));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checkOutput("t3 stall", 64'({bus.m00_axis_tvalid, bus.s00_axis_tready, bus.m00_axis_tlast, bus.m00_axis_tdata}),
                  64'({4'b0100, 4'b0000, 1'b1, 32'hABCD_0100}));
    end
    bus.m00_axis_tready = 4'hF;
    bus.m01_axis_tready = 1'b0;
    @(negedge clk); #1;
    checkOutput("t3 next grant", 64'(bus.s00_axis_tready), 64'(4'b0001));
    @(negedge clk);
    applyStimulus(0, 1'b0, 32'h0005_0007, 1'b0);
    #1;
    checkOutput("t3 issue", 64'({bus.m01_axis_tvalid, bus.m01_axis_tdata}), 64'({1'b1, 32'h0005_0007}));
    repeat (3) @(negedge clk);
    #1;
    checkOutput("t3 issue hold", 64'({busy, bus.m01_axis_tvalid, bus.m01_axis_tdata}), 64'({2'b11, 32'h0005_0007}));
    bus.m01_axis_tready = 1'b1;
    waitReturn(seen);
    checkOutput("t3 ch0 result", 64'({seen, bus.m00_axis_tdata}), 64'({4'b0001, 32'h0005_0008}));

    $display("[TB] engine timeout on ch3");
    repeat (3) @(negedge clk);
    eng_delay = 79;
    @(negedge clk);
    applyStimulus(3, 1'b1, 32'h7777_1111, 1'b0);
    #1;
    checkOutput("t4 grant", 64'(bus.s00_axis_tready), 64'(4'b1000));
    @(negedge clk);
    applyStimulus(3, 1'b0, 32'h7777_1111, 1'b0);
    repeat (64) @(negedge clk);
    #1;
    checkOutput("t4 before timeout", 64'({busy, err_timeout}), 64'(2'b10));
    @(negedge clk); #1;
    checkOutput("t4 timeout", 64'({busy, err_timeout, err_chan}), 64'({1'b0, 1'b1, 2'd3}));
    repeat (15) @(negedge clk);
    #1;
    checkOutput("t4 drain", 64'({bus.s01_axis_tvalid, bus.s01_axis_tready, bus.m00_axis_tvalid}),
                64'({2'b11, 4'b0}));
    @(negedge clk); #1;
    checkOutput("t4 discarded", 64'({busy, bus.s01_axis_tvalid, bus.m00_axis_tvalid}), 64'(6'b0));
    repeat (3) @(negedge clk);
    eng_delay = 17;
    runSingle("t4 recover", 1, 32'h0001_0002, 1'b0, 32'h0001_0003);
    checkOutput("t4 sticky", 64'({err_timeout, err_chan}), 64'({1'b1, 2'd3}));

    $display("[TB] reset during WAIT");
    @(negedge clk);
    applyStimulus(2, 1'b1, 32'h2222_3333, 1'b0);
    #1;
    checkOutput("t5 grant", 64'(bus.s00_axis_tready), 64'(4'b0100));
    @(negedge clk);
    applyStimulus(2, 1'b0, 32'h2222_3333, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    checkOutput("t5 in wait", 64'({busy, bus.s01_axis_tready}), 64'(2'b11));
    rstn = 1'b0;
    @(negedge clk); #1;
    checkOutput("t5 after reset", 64'({busy, bus.m00_axis_tvalid, bus.m01_axis_tvalid, err_timeout}), 64'(7'b0));
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    checkOutput("t5 no pulse", 64'({busy, bus.m00_axis_tvalid}), 64'(5'b0));

    $display("[TB] all channels requesting");
    @(negedge clk);
    for (int c = 0; c < 4; c++) applyStimulus(c, 1'b1, t2_data[c], 1'b0);
    for (int g = 0; g < 5; g++) begin
      oh = 4'b0001 << (g % 4);
      waitGrant(seen);
      checkOutput("t2 grant", 64'(seen), 64'(oh));
      waitReturn(seen);
      checkOutput("t2 result", 64'({seen, bus.m00_axis_tdata}), 64'({oh, t2_res[g % 4]}));
      @(negedge clk);
      if (g == 4) bus.s00_axis_tvalid = '0;
    end
    @(negedge clk); #1;
    checkOutput("t2 idle", 64'({busy, bus.s00_axis_tready}), 64'(5'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
